// File: rtl/cmp_phs_ctrl_if.sv
// Signal bundle between the comparator-clock phase sequencer, its requester and the MMCM.
// master = requester/MMCM side, slave = cmp_phs_ctrl.
interface cmp_phs_ctrl_if #(
  parameter int STEP_W = 11
);
  logic [4:0]        CMP_CLK_PHASE;
  logic              CMP_PHS_CHANGE;
  logic              CMP_PHS_JTAG_RST;
  logic              MMCM_LOCK;
  logic              PSDONE;
  logic              PSEN;
  logic              PSINCDEC;
  logic              MMCM_RST;
  logic              BUSY;
  logic [STEP_W-1:0] CMP_PHASE;
  logic [2:0]        CMP_PHS_STATE;
  logic              PHS_ERR;

  modport master (
    output CMP_CLK_PHASE, CMP_PHS_CHANGE, CMP_PHS_JTAG_RST, MMCM_LOCK, PSDONE,
    input  PSEN, PSINCDEC, MMCM_RST, BUSY, CMP_PHASE, CMP_PHS_STATE, PHS_ERR
  );

  modport slave (
    input  CMP_CLK_PHASE, CMP_PHS_CHANGE, CMP_PHS_JTAG_RST, MMCM_LOCK, PSDONE,
    output PSEN, PSINCDEC, MMCM_RST, BUSY, CMP_PHASE, CMP_PHS_STATE, PHS_ERR
  );
endinterface

// File: rtl/cmp_phs_ctrl.sv
// Dynamic phase-shift sequencer for the comparator-clock MMCM: walks PSEN steps to code*STEPS_PER_CODE.
// Optional PSDONE watchdog enabled by defining CMP_PHS_TIMEOUT_EN.
module cmp_phs_ctrl #(
  parameter int STEP_W         = 11,
  parameter int STEPS_PER_CODE = 35,
  parameter int RST_CYCLES     = 4,
  parameter int TMO_CYCLES     = 255
) (
  input logic            CLK,
  input logic            RST_B,
  cmp_phs_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CALC      = 3'd1;
  localparam logic [2:0] STEP      = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] MRST      = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  if (RST_CYCLES < 1 || TMO_CYCLES < 2 || 31 * STEPS_PER_CODE > 2**STEP_W - 1) begin : g_param_chk
    $error("cmp_phs_ctrl: parameter set out of range");
  end

  logic [2:0]        state_q, state_d;
  logic [4:0]        code_q;
  logic              pend_q;
  logic              jtag_q;
  logic              incdec_q;
  logic [STEP_W-1:0] phase_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [STEP_W-1:0] target;
  logic              jtag_pend;
  logic              lock;

  // Counter saturates: never below zero, never past the current target.
  function automatic logic [STEP_W-1:0] step_phase(input logic [STEP_W-1:0] ph,
                                                   input logic              inc,
                                                   input logic [STEP_W-1:0] tgt);
    if (inc) step_phase = (ph < tgt)  ? ph + 1'b1 : ph;
    else     step_phase = (ph != '0) ? ph - 1'b1 : ph;
  endfunction

  assign target    = STEP_W'(code_q) * STEP_W'(STEPS_PER_CODE);
  assign jtag_pend = jtag_q | bus.CMP_PHS_JTAG_RST;
  assign lock      = bus.MMCM_LOCK;

`ifdef CMP_PHS_TIMEOUT_EN
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_q;
  logic          err_q;
  logic          tmo_hit;

  assign tmo_hit = (state_q == WAIT_DONE) && !bus.PSDONE && (tmo_cnt_q == TW'(TMO_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == WAIT_DONE && !bus.PSDONE) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign bus.PHS_ERR = err_q;
`else
  assign bus.PHS_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (jtag_pend)             state_d = MRST;
        else if (pend_q && lock)   state_d = CALC;
      end
      CALC: begin
        if (jtag_pend)             state_d = MRST;
        else if (!lock)            state_d = WAIT_LOCK;
        else if (phase_q == target) state_d = IDLE;
        else                       state_d = STEP;
      end
      STEP:      state_d = lock ? WAIT_DONE : WAIT_LOCK;
      WAIT_DONE: begin
        // An issued PSEN is always seen through to PSDONE before a reset is honoured.
        if (bus.PSDONE)            state_d = jtag_pend ? MRST : CALC;
`ifdef CMP_PHS_TIMEOUT_EN
        else if (tmo_hit)          state_d = MRST;
`endif
      end
      MRST: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock)                  state_d = (phase_q != target) ? CALC : IDLE;
      end
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pend_q    <= 1'b0;
      jtag_q    <= 1'b0;
      incdec_q  <= 1'b0;
      phase_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // CALC always evaluates the latest code, so entering it consumes the pending request.
      if (bus.CMP_PHS_CHANGE) begin
        code_q <= bus.CMP_CLK_PHASE;
        pend_q <= 1'b1;
      end else if (state_d == CALC) begin
        pend_q <= 1'b0;
      end
      if (bus.CMP_PHS_JTAG_RST)  jtag_q <= 1'b1;
      else if (state_q == MRST)  jtag_q <= 1'b0;
      if (state_q == CALC && state_d == STEP) incdec_q <= (target > phase_q);
      if (state_q == MRST)                          phase_q <= '0;
      else if (state_q == WAIT_DONE && bus.PSDONE)  phase_q <= step_phase(phase_q, incdec_q, target);
      rst_cnt_q <= (state_q == MRST) ? rst_cnt_q + 1'b1 : '0;
    end
  end

  assign bus.PSEN          = (state_q == STEP) && lock;
  assign bus.PSINCDEC      = incdec_q;
  assign bus.MMCM_RST      = (state_q == MRST);
  assign bus.BUSY          = (state_q != IDLE);
  assign bus.CMP_PHASE     = phase_q;
  assign bus.CMP_PHS_STATE = state_q;

endmodule

// File: tb/tb_cmp_phs_ctrl.sv
// Directed + randomized bench for cmp_phs_ctrl with a behavioural MMCM phase-shift model.
module tb_cmp_phs_ctrl;
  localparam int STEP_W = 11;
  localparam int SPC    = 35;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cmp_phs_ctrl_if #(.STEP_W(STEP_W)) bus ();

  cmp_phs_ctrl #(
    .STEP_W(STEP_W), .STEPS_PER_CODE(SPC), .RST_CYCLES(4), .TMO_CYCLES(255)
  ) dut (
    .CLK(clk), .RST_B(rst_b), .bus(bus)
  );

  int vectors = 0, miscompares = 0;
  int mmcm_ph = 0, tgt_code = 0, up_cnt = 0, dn_cnt = 0, dir_err = 0, viol = 0;
  int rst_run = 0, rst_len = 0, psdone_dly = 1, dly_left = 0, relock = 0;
  bit outstanding = 0, force_low = 0, suppress = 0;

  // MMCM model: real phase position, PSDONE after psdone_dly cycles, relock after reset.
  always @(negedge clk) begin
    bus.PSDONE = 1'b0;
    if (!rst_b) begin
      outstanding = 0;
      dly_left    = 0;
    end else begin
      if (outstanding && !suppress) begin
        dly_left--;
        if (dly_left == 0) begin
          bus.PSDONE  = 1'b1;
          outstanding = 0;
        end
      end
      if (bus.PSEN === 1'b1) begin
        if (outstanding || bus.MMCM_LOCK !== 1'b1) viol++;
        if (bus.PSINCDEC !== ((tgt_code * SPC) > mmcm_ph)) dir_err++;
        if (bus.PSINCDEC === 1'b1) begin mmcm_ph++; up_cnt++; end
        else begin mmcm_ph--; dn_cnt++; end
        outstanding = 1;
        dly_left    = psdone_dly;
      end
    end
    if (bus.MMCM_RST === 1'b1) begin
      mmcm_ph     = 0;
      relock      = 8;
      outstanding = 0;
      rst_run++;
    end else begin
      if (rst_run > 0) begin rst_len = rst_run; rst_run = 0; end
      if (relock > 0) relock--;
    end
    bus.MMCM_LOCK = !force_low && (relock == 0) && (bus.MMCM_RST !== 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic request(input int code);
    bus.CMP_CLK_PHASE  = 5'(code);
    bus.CMP_PHS_CHANGE = 1'b1;
    tgt_code = code;
    tick();
    bus.CMP_PHS_CHANGE = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) tick();
    while (bus.BUSY === 1'b1 && n < 8000) begin tick(); n++; end
    if (n >= 8000) check({tag, " idle timeout"}, 1, 0);
  endtask

  task automatic seek(input string tag, input int code);
    int u0, d0, old_ph, new_ph;
    u0 = up_cnt; d0 = dn_cnt; old_ph = mmcm_ph; new_ph = code * SPC;
    request(code);
    wait_idle(tag);
    check({tag, " phase"}, int'(bus.CMP_PHASE), new_ph);
    check({tag, " up steps"}, up_cnt - u0, (new_ph > old_ph) ? new_ph - old_ph : 0);
    check({tag, " down steps"}, dn_cnt - d0, (old_ph > new_ph) ? old_ph - new_ph : 0);
    check({tag, " state"}, int'(bus.CMP_PHS_STATE), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " PSEN"},     int'(bus.PSEN), 0);
    check({tag, " PSINCDEC"}, int'(bus.PSINCDEC), 0);
    check({tag, " MMCM_RST"}, int'(bus.MMCM_RST), 0);
    check({tag, " BUSY"},     int'(bus.BUSY), 0);
    check({tag, " phase"},    int'(bus.CMP_PHASE), 0);
    check({tag, " PHS_ERR"},  int'(bus.PHS_ERR), 0);
    check({tag, " state"},    int'(bus.CMP_PHS_STATE), 0);
  endtask

  initial begin
    int n, u0, d0, wd;
    bus.CMP_CLK_PHASE    = '0;
    bus.CMP_PHS_CHANGE   = 1'b0;
    bus.CMP_PHS_JTAG_RST = 1'b0;
    rst_b = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_b = 1'b1;
    tick();

    // Seek up to code 2 and follow the tail of the state sequence.
    u0 = up_cnt;
    request(2);
    n = 0;
    while (up_cnt - u0 < 70 && n < 2000) begin tick(); n++; end
    check("up2 pulses", up_cnt - u0, 70);
    check("up2 last STEP", int'(bus.CMP_PHS_STATE), 2);
    tick(); check("up2 WAIT_DONE", int'(bus.CMP_PHS_STATE), 3);
    tick(); check("up2 CALC", int'(bus.CMP_PHS_STATE), 1);
    check("up2 busy in CALC", int'(bus.BUSY), 1);
    tick(); check("up2 IDLE", int'(bus.CMP_PHS_STATE), 0);
    check("up2 busy low", int'(bus.BUSY), 0);
    check("up2 phase", int'(bus.CMP_PHASE), 70);
    check("up2 no downs", dn_cnt, 0);
    check("up2 incdec", int'(bus.PSINCDEC), 1);

    // JTAG reset at phase 70, then automatic re-seek.
    u0 = up_cnt;
    bus.CMP_PHS_JTAG_RST = 1'b1;
    tick();
    bus.CMP_PHS_JTAG_RST = 1'b0;
    n = 0;
    while (bus.CMP_PHS_STATE !== 3'd5 && n < 50) begin tick(); n++; end
    check("jtag WAIT_LOCK", int'(bus.CMP_PHS_STATE), 5);
    check("jtag phase cleared", int'(bus.CMP_PHASE), 0);
    check("jtag rst released", int'(bus.MMCM_RST), 0);
    check("jtag rst length", rst_len, 4);
    wait_idle("jtag");
    check("jtag reseek phase", int'(bus.CMP_PHASE), 70);
    check("jtag reseek ups", up_cnt - u0, 70);

    // Mid-seek change: head for code 3, redirect to code 1 after 50 steps.
    seek("to0", 0);
    u0 = up_cnt; d0 = dn_cnt;
    request(3);
    n = 0;
    while (!(up_cnt - u0 == 50 && bus.PSDONE === 1'b1) && n < 500) begin tick(); n++; end
    check("mid 50 steps", up_cnt - u0, 50);
    request(1);
    wait_idle("mid");
    check("mid phase", int'(bus.CMP_PHASE), 35);
    check("mid ups", up_cnt - u0, 50);
    check("mid downs", dn_cnt - d0, 15);
    check("mid model phase", mmcm_ph, 35);

    // Request while unlocked is held until lock returns.
    force_low = 1;
    tick();
    u0 = up_cnt;
    request(4);
    repeat (20) tick();
    check("unlock busy", int'(bus.BUSY), 0);
    check("unlock state", int'(bus.CMP_PHS_STATE), 0);
    check("unlock no psen", up_cnt - u0, 0);
    force_low = 0;
    wait_idle("unlock");
    check("unlock phase", int'(bus.CMP_PHASE), 140);
    check("unlock ups", up_cnt - u0, 105);

    // Random targets with random PSDONE latency.
    for (int i = 0; i < 6; i++) begin
      psdone_dly = $urandom_range(1, 3);
      seek("rand", $urandom_range(0, 31));
    end
    psdone_dly = 1;

    // Asynchronous reset while a step is outstanding.
    request((tgt_code + 10) % 32);
    n = 0;
    while (bus.CMP_PHS_STATE !== 3'd3 && n < 50) begin tick(); n++; end
    check("arst in WAIT_DONE", int'(bus.CMP_PHS_STATE), 3);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_vals("arst");
    mmcm_ph  = 0;
    tgt_code = 0;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    seek("after arst", 1);

`ifdef CMP_PHS_TIMEOUT_EN
    suppress = 1;
    request(2);
    n = 0;
    while (bus.CMP_PHS_STATE !== 3'd3 && n < 50) begin tick(); n++; end
    wd = 0;
    while (bus.CMP_PHS_STATE === 3'd3 && wd < 400) begin wd++; tick(); end
    check("tmo wait cycles", wd, 255);
    check("tmo err set", int'(bus.PHS_ERR), 1);
    check("tmo MRST", int'(bus.CMP_PHS_STATE), 4);
    suppress = 0;
    wait_idle("tmo");
    check("tmo reseek phase", int'(bus.CMP_PHASE), 70);
    check("tmo err sticky", int'(bus.PHS_ERR), 1);
`else
    wd = 0;
    check("phs_err tied", int'(bus.PHS_ERR) + wd, 0);
`endif

    check("protocol violations", viol, 0);
    check("direction errors", dir_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
